// File: rtl/pio_irq_in_multi.sv
// Multi-bit interrupt-capable input port on an Avalon-MM slave.
// Each bit: synchroniser, optional glitch filter, rise/fall/level capture into a W1C register, masked irq.
module pio_irq_in_multi #(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_dly_q;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] level_mode_q, level_mode_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;

    always_comb begin
        sync_d[0] = in_port;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '{default: '0};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_no_filter
            assign filt = sync;
        end else begin : g_filter
            localparam logic [7:0] LAST = 8'(FILTER_CYCLES - 1);
            logic [7:0]       cnt_q [WIDTH];
            logic [7:0]       cnt_d [WIDTH];
            logic [WIDTH-1:0] filt_q, filt_d;

            // Counter runs only while sync disagrees with filt; the Nth disagreeing cycle commits.
            always_comb begin
                filt_d = filt_q;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = 8'd0;
                    if (sync[i] != filt_q[i]) begin
                        if (cnt_q[i] == LAST) begin
                            filt_d[i] = sync[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    filt_q <= '0;
                    cnt_q  <= '{default: '0};
                end else begin
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign filt = filt_q;
        end

        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    assign wr_en   = chipselect && !write_n;
    assign wdata   = writedata[WIDTH-1:0];
    assign cap_set = (rise_en_q & filt & ~filt_dly_q)
                   | (fall_en_q & ~filt & filt_dly_q)
                   | (level_mode_q & filt);
    assign cap_clr = (wr_en && address == 3'd3) ? wdata : '0;

    always_comb begin
        rise_en_d    = rise_en_q;
        irq_mask_d   = irq_mask_q;
        fall_en_d    = fall_en_q;
        level_mode_d = level_mode_q;
        if (wr_en) begin
            case (address)
                3'd1:    rise_en_d    = wdata;
                3'd2:    irq_mask_d   = wdata;
                3'd4:    fall_en_d    = wdata;
                3'd5:    level_mode_d = wdata;
                default: ;
            endcase
        end
        // Set is applied after clear so a coincident event is never lost.
        capture_d = (capture_q & ~cap_clr) | cap_set;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0:    readdata_d[WIDTH-1:0] = filt;
            3'd1:    readdata_d[WIDTH-1:0] = rise_en_q;
            3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            3'd3:    readdata_d[WIDTH-1:0] = capture_q;
            3'd4:    readdata_d[WIDTH-1:0] = fall_en_q;
            3'd5:    readdata_d[WIDTH-1:0] = level_mode_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_dly_q   <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            level_mode_q <= '0;
            irq_mask_q   <= '0;
            capture_q    <= '0;
            readdata_q   <= '0;
        end else begin
            filt_dly_q   <= filt;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            level_mode_q <= level_mode_d;
            irq_mask_q   <= irq_mask_d;
            capture_q    <= capture_d;
            readdata_q   <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(capture_q & irq_mask_q);

endmodule

// File: tb/tb_pio_irq_in_multi.sv
// Self-checking bench for pio_irq_in_multi (WIDTH=4, SYNC_STAGES=2, FILTER_CYCLES=3).
module tb_pio_irq_in_multi;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] in_port;
    logic         irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    pio_irq_in_multi #(
        .WIDTH(W),
        .SYNC_STAGES(2),
        .FILTER_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Expected value is queued when the address is driven and compared when readdata appears.
    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        tick();
        check(name_q.pop_front(), readdata, exp_q.pop_front());
        chipselect = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3'd1, 32'hFFFF_FFA5, 32'h5, "rise_en rw"};
        vecs[1] = '{3'd2, 32'h0000_000A, 32'hA, "irq_mask rw"};
        vecs[2] = '{3'd4, 32'h0000_0003, 32'h3, "fall_en rw"};
        vecs[3] = '{3'd5, 32'h0000_000C, 32'hC, "level_mode rw"};
        vecs[4] = '{3'd6, 32'h0000_000F, 32'h0, "addr6 ignored"};
        vecs[5] = '{3'd7, 32'h0000_000F, 32'h0, "addr7 ignored"};
        vecs[6] = '{3'd0, 32'h0000_000F, 32'h0, "data read-only"};
        vecs[7] = '{3'd3, 32'h0000_000F, 32'h0, "capture w1c idle"};

        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        repeat (3) tick();
        check("irq in reset", {31'd0, irq}, 32'd0);
        check("readdata in reset", readdata, 32'd0);
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 32'd0, $sformatf("reset value addr%0d", a));
        end

        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        check("irq idle", {31'd0, irq}, 32'd0);
        wr(3'd1, 0); wr(3'd2, 0); wr(3'd4, 0); wr(3'd5, 0);

        // Rising edge through sync + 3-cycle filter: capture lands exactly 5 edges after sampling.
        wr(3'd1, 32'h1);
        wr(3'd2, 32'h1);
        in_port[0] = 1'b1;
        tick();
        repeat (4) tick();
        check("rise irq not early", {31'd0, irq}, 32'd0);
        tick();
        check("rise irq on time", {31'd0, irq}, 32'd1);
        rd(3'd3, 32'h1, "capture after rise");
        rd(3'd0, 32'h1, "data high");
        wr(3'd3, 32'h1);
        check("read during clear is pre-clear", readdata, 32'h1);
        check("irq after clear", {31'd0, irq}, 32'd0);
        rd(3'd3, 32'h0, "capture cleared");

        // Glitch rejection
        in_port[0] = 1'b0;
        repeat (8) tick();
        in_port[0] = 1'b1;
        repeat (2) tick();
        in_port[0] = 1'b0;
        repeat (10) tick();
        rd(3'd0, 32'h0, "glitch data");
        rd(3'd3, 32'h0, "glitch capture");
        check("glitch irq", {31'd0, irq}, 32'd0);
        in_port[0] = 1'b1;
        repeat (3) tick();
        in_port[0] = 1'b0;
        repeat (10) tick();
        rd(3'd3, 32'h1, "3-cycle pulse captured");
        wr(3'd3, 32'h1);

        // Falling edge and masking
        wr(3'd2, 32'h0);
        wr(3'd4, 32'h4);
        in_port[2] = 1'b1;
        repeat (8) tick();
        rd(3'd3, 32'h0, "no capture on bit2 rise");
        in_port[2] = 1'b0;
        repeat (8) tick();
        rd(3'd3, 32'h4, "fall capture");
        check("fall irq masked", {31'd0, irq}, 32'd0);
        wr(3'd2, 32'h4);
        check("irq after mask write", {31'd0, irq}, 32'd1);
        wr(3'd3, 32'h3);
        rd(3'd3, 32'h4, "w1c other bits unaffected");
        wr(3'd3, 32'h4);
        check("irq after fall clear", {31'd0, irq}, 32'd0);

        // Set/clear collision on bit 1
        wr(3'd1, 32'h2);
        wr(3'd2, 32'h2);
        in_port[1] = 1'b1;
        tick();
        repeat (4) tick();
        check("pre-collision irq", {31'd0, irq}, 32'd0);
        wr(3'd3, 32'h2);
        check("collision irq", {31'd0, irq}, 32'd1);
        rd(3'd3, 32'h2, "collision capture");
        wr(3'd3, 32'h2);
        rd(3'd3, 32'h0, "clear sticks with no new edge");

        // Enabling rise while filt already high is not an edge
        in_port[3] = 1'b1;
        repeat (8) tick();
        wr(3'd1, 32'hA);
        repeat (3) tick();
        rd(3'd3, 32'h0, "enable while high no edge");
        in_port[3] = 1'b0;
        repeat (8) tick();

        // Level mode
        wr(3'd5, 32'h8);
        wr(3'd2, 32'h8);
        in_port[3] = 1'b1;
        repeat (8) tick();
        rd(3'd3, 32'h8, "level capture");
        wr(3'd3, 32'h8);
        rd(3'd3, 32'h8, "level re-set after clear");
        check("level irq", {31'd0, irq}, 32'd1);
        in_port[3] = 1'b0;
        repeat (8) tick();
        wr(3'd3, 32'h8);
        rd(3'd3, 32'h0, "level clear after input low");
        check("level irq low", {31'd0, irq}, 32'd0);

        // Asynchronous reset mid-operation
        wr(3'd5, 32'hF);
        wr(3'd2, 32'hF);
        in_port = 4'hF;
        repeat (8) tick();
        rd(3'd3, 32'hF, "capture all");
        check("irq before reset", {31'd0, irq}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("irq async drop", {31'd0, irq}, 32'd0);
        check("readdata async clear", readdata, 32'd0);
        in_port = '0;
        #2;
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 32'd0, $sformatf("post-reset addr%0d", a));
        end
        check("irq post-reset", {31'd0, irq}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
